// File: rtl/turn_input_ctrl.sv
// Turn-button front end: per-button synchronizer + debouncer, and a
// single pending-turn register consumed by the game-step tick.

// One button path: 2-flop synchronizer, debounced level, run counter.
module turn_input_ctrl_deb #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,      // asynchronous, 0 = pressed
   output logic db,       // debounced, 1 = pressed
   output logic press     // db rises on this edge
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;
   logic             differ, expire;

   // The synchronized level is active-low; compare it in pressed polarity.
   assign differ = (~s2) != db;
   assign expire = differ && (cnt == LAST);
   assign press  = expire && !db;

   // Synchronize, then flip db only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= 1'b1;
         s2  <= 1'b1;
         db  <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (!differ) begin
            cnt <= '0;
         end else if (expire) begin
            cnt <= '0;
            db  <= ~db;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module turn_input_ctrl #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btL,
   input  logic btR,
   input  logic tick,
   output logic turn_left,
   output logic turn_right,
   output logic held_l,
   output logic held_r,
   output logic overrun
);
   typedef enum logic [1:0] {
      NONE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   // Index 0 = left, 1 = right.
   logic [1:0] raw, db, press;
   state_t     state, state_n;
   logic       ovr_n;

   assign raw = {btR, btL};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         turn_input_ctrl_deb #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
         ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[gi]),
            .db    (db[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   assign held_l     = db[0];
   assign held_r     = db[1];
   assign turn_left  = (state == LEFT);
   assign turn_right = (state == RIGHT);

   // Pending request and overwrite pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= NONE;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         overrun <= ovr_n;
      end
   end

   // Press events beat tick; simultaneous presses cancel each other out.
   always_comb begin
      state_n = state;
      ovr_n   = 1'b0;
      if (press[0] && press[1]) begin
         state_n = state;
      end else if (press[0]) begin
         state_n = LEFT;
         ovr_n   = (state != NONE);
      end else if (press[1]) begin
         state_n = RIGHT;
         ovr_n   = (state != NONE);
      end else if (tick) begin
         state_n = NONE;
      end
   end
endmodule

// File: tb/tb_turn_input_ctrl.sv
// Bench for turn_input_ctrl: directed test-plan steps followed by random
// button/tick traffic, all checked against a sample-window reference model.
module tb_turn_input_ctrl;
   localparam int DEB = 4;

   logic clk = 1'b0, rst_n = 1'b0, btL = 1'b1, btR = 1'b1, tick = 1'b0;
   logic turn_left, turn_right, held_l, held_r, overrun;

   int checks = 0, errors = 0;

   // Reference model: raw samples delayed two edges, a window of the last DEB
   // synchronized pressed levels, debounced levels, pending direction (0/1/2).
   bit rq[2][$];
   bit wq[2][$];
   bit mdb[2];
   int pend;
   bit movr;

   always #5 clk = ~clk;

   turn_input_ctrl #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btL        (btL),
      .btR        (btR),
      .tick       (tick),
      .turn_left  (turn_left),
      .turn_right (turn_right),
      .held_l     (held_l),
      .held_r     (held_r),
      .overrun    (overrun)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         rq[b].delete();
         rq[b].push_back(1'b1);
         rq[b].push_back(1'b1);
         wq[b].delete();
         mdb[b] = 1'b0;
      end
      pend = 0;
      movr = 1'b0;
   endtask

   // Debounced level flips once the last DEB synchronized samples all disagree.
   task automatic model_edge();
      bit ev[2];
      bit rw[2];
      bit s, all;
      if (!rst_n) return;
      rw[0] = btL;
      rw[1] = btR;
      for (int b = 0; b < 2; b++) begin
         s = !rq[b][0];
         void'(rq[b].pop_front());
         rq[b].push_back(rw[b]);
         wq[b].push_back(s);
         if (wq[b].size() > DEB) void'(wq[b].pop_front());
         ev[b] = 1'b0;
         if (wq[b].size() == DEB) begin
            all = 1'b1;
            foreach (wq[b][i]) if (wq[b][i] == mdb[b]) all = 1'b0;
            if (all) begin
               mdb[b] = !mdb[b];
               ev[b]  = mdb[b];
            end
         end
      end
      movr = 1'b0;
      if (ev[0] && ev[1]) begin
      end else if (ev[0] || ev[1]) begin
         movr = (pend != 0);
         pend = ev[0] ? 1 : 2;
      end else if (tick) begin
         pend = 0;
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, "_turn_left"},  turn_left,  pend == 1);
      chk({tag, "_turn_right"}, turn_right, pend == 2);
      chk({tag, "_held_l"},     held_l,     mdb[0]);
      chk({tag, "_held_r"},     held_r,     mdb[1]);
      chk({tag, "_overrun"},    overrun,    movr);
   endtask

   // One clock: model advances on the rising edge, outputs checked on the falling edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         compare("step");
      end
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      compare("reset");
      step(3);
      rst_n = 1'b1;
      step(2);

      // Basic press: rises on edge 5, holds, tick clears it while still held.
      btL = 1'b0;
      step(5);
      chk("basic_before_edge5", turn_left, 1'b0);
      step();
      chk("basic_at_edge5", turn_left, 1'b1);
      step(14);
      chk("basic_held", turn_left, 1'b1);
      pulse_tick();
      chk("basic_consumed", turn_left, 1'b0);
      step(10);
      chk("basic_no_repeat", turn_left, 1'b0);
      btL = 1'b1;
      step(10);

      // Glitch of 3 cycles rejected, 4 cycles accepted.
      btR = 1'b0;
      step(3);
      btR = 1'b1;
      step(10);
      chk("glitch3_held_r", held_r, 1'b0);
      chk("glitch3_turn_right", turn_right, 1'b0);
      btR = 1'b0;
      step(4);
      btR = 1'b1;
      step(10);
      chk("glitch4_turn_right", turn_right, 1'b1);
      pulse_tick();

      // Overwrite: LEFT then RIGHT without tick.
      btL = 1'b0;
      step(8);
      btL = 1'b1;
      step(8);
      btR = 1'b0;
      step(6);
      chk("overwrite_pulse", overrun, 1'b1);
      chk("overwrite_left_gone", turn_left, 1'b0);
      step();
      chk("overwrite_pulse_end", overrun, 1'b0);
      btR = 1'b1;
      step(8);
      pulse_tick();

      // Press event and tick on the same edge.
      btL = 1'b0;
      step(8);
      btL = 1'b1;
      step(8);
      btR = 1'b0;
      step(5);
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("same_edge_right", turn_right, 1'b1);
      chk("same_edge_overrun", overrun, 1'b1);
      pulse_tick();
      chk("same_edge_cleared", turn_right, 1'b0);
      btR = 1'b1;
      step(8);

      // Simultaneous presses cancel.
      btL = 1'b0;
      btR = 1'b0;
      step(8);
      chk("simul_held_l", held_l, 1'b1);
      chk("simul_held_r", held_r, 1'b1);
      chk("simul_none", turn_left | turn_right, 1'b0);
      btL = 1'b1;
      btR = 1'b1;
      step(8);

      // Reset with LEFT pending and right mid-debounce.
      btL = 1'b0;
      step(8);
      btL = 1'b1;
      step(8);
      btR = 1'b0;
      step(4);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare("async_reset");
      chk("async_reset_left", turn_left, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(5);
      chk("post_reset_before", turn_right, 1'b0);
      step();
      chk("post_reset_right", turn_right, 1'b1);
      btR = 1'b1;
      step(8);
      pulse_tick();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) btL = ~btL;
         if ($urandom_range(0, 5) == 0) btR = ~btR;
         tick = ($urandom_range(0, 3) == 0);
         step();
      end
      tick = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
